bin2bcd_8digit: RTL and testbench
=================================

// Module: bin2bcd_8digit
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3, "double dabble") for the 8-digit 7-seg Pmod.
//  Sits directly upstream of the 8-digit 74HC595 scan driver.
//  Turns a binary count/value into 8 packed BCD nibbles.
//  The driver shifts each nibble out as one digit, with no software divide-by-10.
// PARAMETERS
//  BIN_W   27  width of binary input; 27 bits covers 99_999_999
//  DIGITS  8   number of BCD digits produced; fixed by the display
// PORTS
//  clk           in   1        system clock; the only clock
//  rst           in   1        asynchronous, active-high reset
//  in_valid      in   1        in_bin holds a value to convert
//  in_ready      out  1        converter idle; can accept a value
//  in_bin        in   BIN_W    unsigned binary value
//  out_valid     out  1        1-cycle pulse; new out_bcd is valid
//  out_bcd       out  4*DIGITS packed BCD; [3:0]=ones digit, [31:28]=10^7 digit
//  out_overflow  out  1        last result was saturated (in_bin > 99_999_999)
//  busy          out  1        conversion in progress (state != IDLE)
//  out_blank     out  DIGITS   leading-zero mask; present only with the macro
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, out_bcd=0, out_overflow=0, busy=0, out_blank=0.
//    All internal shift/BCD registers are cleared.
//  - FSM: IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE: in_ready=1.
//    - Transfer occurs on the clk edge with in_valid&&in_ready.
//    - At transfer: latch in_bin into bin_sr, clear bcd_sr, set iter=0.
//    - At transfer: ovf_q = (in_bin > 99_999_999), registered.
//    - Go to SHIFT.
//  - SHIFT: in_ready=0.
//    - Each cycle, every nibble of bcd_sr >= 5 gets +3 (4-bit, no carry out of nibble).
//    - Then {bcd_sr,bin_sr} shifts left by 1.
//    - iter increments; after BIN_W shifts (iter==BIN_W-1), go to DONE.
//  - DONE, one cycle:
//    - out_bcd <= ovf_q ? 32'h9999_9999 : bcd_sr; out_overflow <= ovf_q.
//    - out_valid <= 1 for exactly that one cycle.
//    - Next state is IDLE.
//  - Latency: out_valid is high at the clk edge BIN_W+1 cycles after the accepting edge (28 with defaults).
//  - Throughput: one conversion per BIN_W+2 cycles.
//  - in_valid held high is accepted again on the first IDLE cycle.
//  - out_bcd/out_overflow hold their last value until the next DONE; they never show partial results.
//  - in_bin/in_valid changes while not in IDLE are ignored; there is no queueing.
//  - iter width is clog2(BIN_W). With BIN_W not a power of two it never wraps before the terminal compare.
//  - rst asserted mid-conversion:
//    - immediate abort, no out_valid.
//    - out_bcd returns to 0.
//    - in_ready=1 in the first cycle after rst deasserts.
// CONFIGURATION
//  - Macro LEADING_ZERO_BLANK_EN.
//    - Defined: out_blank port exists and is registered at DONE with out_bcd.
//    - out_blank[i]=1 iff digit i and all higher digits are 0, for i=1..7.
//    - out_blank[0] is always 0; the ones digit is never blanked.
//    - Saturated output gives out_blank=0.
//  - Undefined: out_blank port and its logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Package digit8_pkg:
//    - DIGITS=8, BCD_W=4, MAX_DEC=27'd99_999_999, SAT_BCD=32'h9999_9999.
//    - State encoding localparams ST_IDLE/ST_SHIFT/ST_DONE (2 bits).
//  - Sub-module bcd_digit_adj: combinational 4-bit in -> 4-bit out (x>=5 ? x+3 : x).
//    - Instantiated DIGITS times in a generate loop.
//  - Top holds FSM, iter counter, bin_sr/bcd_sr, overflow flag, output regs and optional blank logic.
// TESTING
//  1. Reset: assert rst mid-cycle -> in_ready=1, busy=0, out_valid=0, out_bcd=0 immediately (async).
//  2. in_bin=12_345_678 -> out_valid exactly 28 cycles after accept; out_bcd=32'h1234_5678, out_overflow=0.
//  3. in_bin=0 -> out_bcd=0; with LEADING_ZERO_BLANK_EN, out_blank=8'hFE.
//     in_bin=1239 -> out_bcd=32'h0000_1239, out_blank=8'hF0.
//  4. in_bin=99_999_999 -> 32'h9999_9999, out_overflow=0.
//     in_bin=100_000_000 and 27'h7FF_FFFF -> 32'h9999_9999, out_overflow=1.
//  5. in_valid held high with values 5, then 42:
//     - second accept occurs on the cycle after out_valid.
//     - results are 32'h5 then 32'h42, 29 cycles apart.
//     - inputs changed during SHIFT are ignored.
//  6. Accept 87_654_321, then pulse rst after 10 SHIFT cycles -> no out_valid.
//     Re-issue after reset -> 32'h8765_4321 with normal latency.

Source files
------------

// File: rtl/digit8_pkg.sv
// Shared constants and FSM state type for the 8-digit binary-to-BCD converter.
package digit8_pkg;

    localparam int DIGITS = 8;
    localparam int BCD_W  = 4;

    localparam logic [26:0] MAX_DEC = 27'd99_999_999;
    localparam logic [31:0] SAT_BCD = 32'h9999_9999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 before the next shift.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/bin2bcd_8digit.sv
// Sequential shift-and-add-3 binary-to-BCD converter feeding the 8-digit scan driver.
// Define LEADING_ZERO_BLANK_EN to add the registered out_blank leading-zero mask.
module bin2bcd_8digit #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_overflow,
    output logic                  busy
`ifdef LEADING_ZERO_BLANK_EN
    ,
    output logic [DIGITS-1:0]     out_blank
`endif
);

    import digit8_pkg::*;

    localparam int IW = $clog2(BIN_W);

    state_t                state, state_nxt;
    logic [BIN_W-1:0]      bin_sr;
    logic [4*DIGITS-1:0]   bcd_sr;
    logic [4*DIGITS-1:0]   bcd_adj;
    logic [IW-1:0]         iter;
    logic                  ovf_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (bcd_sr [g*BCD_W +: BCD_W]),
            .adjusted (bcd_adj[g*BCD_W +: BCD_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: next state defaults to the current one first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (in_valid) state_nxt = ST_SHIFT;
            ST_SHIFT: if (iter == IW'(BIN_W-1)) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_sr <= '0;
            bcd_sr <= '0;
            iter   <= '0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    bin_sr <= in_bin;
                    bcd_sr <= '0;
                    iter   <= '0;
                    ovf_q  <= (32'(in_bin) > 32'(MAX_DEC));
                end
                ST_SHIFT: begin
                    // Corrected digits and the binary register shift left as one long register.
                    bcd_sr <= {bcd_adj[4*DIGITS-2:0], bin_sr[BIN_W-1]};
                    bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
                    iter   <= iter + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_bcd      <= '0;
            out_overflow <= 1'b0;
        end else begin
            out_valid <= (state == ST_DONE);
            if (state == ST_DONE) begin
                out_bcd      <= ovf_q ? SAT_BCD : bcd_sr;
                out_overflow <= ovf_q;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_nxt;
    logic              zero_above;

    // Walk down from the top digit; a digit blanks only while everything above it is zero.
    always_comb begin
        blank_nxt  = '0;
        zero_above = 1'b1;
        for (int i = DIGITS-1; i >= 1; i--) begin
            zero_above   = zero_above && (bcd_sr[i*BCD_W +: BCD_W] == '0);
            blank_nxt[i] = zero_above && !ovf_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    out_blank <= '0;
        else if (state == ST_DONE)  out_blank <= blank_nxt;
    end
`endif

endmodule

// File: tb/tb_bin2bcd_8digit.sv
// Randomized self-checking bench for bin2bcd_8digit against an arithmetic decimal model.
module tb_bin2bcd_8digit;

    localparam int BIN_W   = 27;
    localparam int DIGITS  = 8;
    localparam int LATENCY = BIN_W + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [BIN_W-1:0]   in_bin;
    logic               out_valid;
    logic [31:0]        out_bcd;
    logic               out_overflow;
    logic               busy;
    logic [7:0]         blank_obs;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          t;
        logic [31:0] bcd;
        logic        ovf;
        logic [7:0]  blank;
    } ev_t;
    ev_t evq[$];

`ifdef LEADING_ZERO_BLANK_EN
    logic [7:0] out_blank;
    assign blank_obs = out_blank;
`else
    assign blank_obs = 8'h00;
`endif

    bin2bcd_8digit #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_bin       (in_bin),
        .out_valid    (out_valid),
        .out_bcd      (out_bcd),
        .out_overflow (out_overflow),
        .busy         (busy)
`ifdef LEADING_ZERO_BLANK_EN
        ,
        .out_blank    (out_blank)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (!rst && out_valid) evq.push_back('{cyc, out_bcd, out_overflow, blank_obs});

    // Decimal digits by repeated division; out-of-range values saturate to all nines.
    function automatic logic [31:0] ref_bcd(input longint v);
        logic [31:0] r;
        longint      x;
        if (v > 64'd99_999_999) return 32'h9999_9999;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input longint v);
        return v > 64'd99_999_999;
    endfunction

    // Digit i is a leading zero exactly when the value is below 10**i.
    function automatic logic [7:0] ref_blank(input longint v);
        logic [7:0] b;
        longint     p;
        b = '0;
`ifdef LEADING_ZERO_BLANK_EN
        if (v <= 64'd99_999_999) begin
            p = 1;
            for (int i = 1; i < 8; i++) begin
                p = p * 10;
                b[i] = (v < p);
            end
        end
`else
        p = v;
`endif
        return b;
    endfunction

    task automatic check_event(input ev_t ev, input longint v, input string name);
        checks++;
        if (ev.bcd !== ref_bcd(v)) begin
            errors++;
            $display("FAIL %s out_bcd got %h expected %h", name, ev.bcd, ref_bcd(v));
        end
        checks++;
        if (ev.ovf !== ref_ovf(v)) begin
            errors++;
            $display("FAIL %s out_overflow got %b expected %b", name, ev.ovf, ref_ovf(v));
        end
`ifdef LEADING_ZERO_BLANK_EN
        checks++;
        if (ev.blank !== ref_blank(v)) begin
            errors++;
            $display("FAIL %s out_blank got %h expected %h", name, ev.blank, ref_blank(v));
        end
`endif
    endtask

    // Presents one value, checks the handshake and latency, and scrambles in_bin while busy.
    task automatic run_one(input logic [BIN_W-1:0] v, input string name);
        int acc;
        int guard;
        evq.delete();
        @(negedge clk);
        in_valid = 1'b1;
        in_bin   = v;
        guard    = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        acc      = cyc;
        in_valid = 1'b0;
        in_bin   = BIN_W'($urandom);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s busy/in_ready after accept got %b/%b expected 1/0", name, busy, in_ready);
        end
        guard = 0;
        while (evq.size() == 0 && guard < LATENCY + 20) begin
            @(negedge clk);
            #1;
            in_bin = BIN_W'($urandom);
            guard++;
        end
        checks++;
        if (evq.size() == 0) begin
            errors++;
            $display("FAIL %s out_valid timeout got none expected one", name);
        end else begin
            checks++;
            if (evq[0].t - acc !== LATENCY) begin
                errors++;
                $display("FAIL %s latency got %0d expected %0d", name, evq[0].t - acc, LATENCY);
            end
            check_event(evq[0], longint'(v), name);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_bin   = '0;
        #2;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_bcd !== 32'h0) begin
            errors++;
            $display("FAIL reset_init got ready=%b busy=%b valid=%b bcd=%h expected 1 0 0 00000000",
                     in_ready, busy, out_valid, out_bcd);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_one(BIN_W'(12_345_678), "pre_reset");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_bcd !== 32'h0) begin
            errors++;
            $display("FAIL reset_async got ready=%b busy=%b valid=%b bcd=%h expected 1 0 0 00000000",
                     in_ready, busy, out_valid, out_bcd);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_one(BIN_W'(12_345_678), "dir_12345678");
        run_one(BIN_W'(0),          "dir_zero");
        run_one(BIN_W'(1239),       "dir_1239");
        run_one(BIN_W'(10),         "dir_10");
        run_one(BIN_W'(5),          "dir_5");
    endtask

    task automatic test_overflow();
        run_one(BIN_W'(99_999_999),  "ovf_max_dec");
        run_one(BIN_W'(100_000_000), "ovf_first");
        run_one(27'h7FF_FFFF,        "ovf_all_ones");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++)
            run_one(BIN_W'($urandom_range(99_999_999, 0)), "rand_in_range");
        for (int i = 0; i < 4; i++)
            run_one(BIN_W'($urandom_range(134_217_727, 100_000_000)), "rand_overflow");
    endtask

    task automatic test_back_to_back();
        int acc;
        int guard;
        evq.delete();
        @(negedge clk);
        in_valid = 1'b1;
        in_bin   = BIN_W'(5);
        @(posedge clk);
        #1;
        acc   = cyc;
        guard = 0;
        while (evq.size() < 2 && guard < 2 * LATENCY + 20) begin
            @(negedge clk);
            #1;
            if (out_valid && evq.size() == 1) in_bin = BIN_W'(42);
            else                              in_bin = BIN_W'($urandom);
            guard++;
        end
        in_valid = 1'b0;
        checks++;
        if (evq.size() != 2) begin
            errors++;
            $display("FAIL b2b result_count got %0d expected 2", evq.size());
        end else begin
            checks++;
            if (evq[0].t - acc !== LATENCY) begin
                errors++;
                $display("FAIL b2b first_latency got %0d expected %0d", evq[0].t - acc, LATENCY);
            end
            checks++;
            if (evq[1].t - evq[0].t !== BIN_W + 2) begin
                errors++;
                $display("FAIL b2b spacing got %0d expected %0d", evq[1].t - evq[0].t, BIN_W + 2);
            end
            check_event(evq[0], 5,  "b2b_first");
            check_event(evq[1], 42, "b2b_second");
        end
        repeat (2 * LATENCY) @(negedge clk);
    endtask

    task automatic test_abort();
        evq.delete();
        @(negedge clk);
        in_valid = 1'b1;
        in_bin   = BIN_W'(87_654_321);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_bcd !== 32'h0) begin
            errors++;
            $display("FAIL abort_async got ready=%b busy=%b valid=%b bcd=%h expected 1 0 0 00000000",
                     in_ready, busy, out_valid, out_bcd);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready_after_release got %b expected 1", in_ready);
        end
        repeat (LATENCY + 10) @(negedge clk);
        checks++;
        if (evq.size() != 0) begin
            errors++;
            $display("FAIL abort_no_valid got %0d results expected 0", evq.size());
        end
        run_one(BIN_W'(87_654_321), "abort_reissue");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_overflow();
        test_random();
        test_back_to_back();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
